psum_accum_core: RTL

- Parametrised successor to the corelet output path. Sits between mac_array out_s/valid and the L2/output SRAM write port.
- Generalises the fixed 3-stage valid shift register to a parameter-depth delay line on valid and data.
- Accumulates partial sums per column over a programmable number of passes into a DEPTH-entry accumulator bank, then drains results through a valid/ready handshake.
- Adds optional ReLU, saturation and drop/overflow status that the current corelet lacks.

---
 rtl/psum_accum_core_if.sv | 16 +
 rtl/psum_accum_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_core_if.sv
// Stream bundle: skewed per-column psums in from mac_array, one drained
// accumulator entry (all columns) out towards the output SRAM write port.
interface psum_accum_core_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20
);
    logic [col-1:0]         in_valid;
    logic [col*psum_bw-1:0] in_psum;
    logic                   out_valid;
    logic                   out_ready;
    logic [col*acc_bw-1:0]  out_data;

    modport master (output in_valid, in_psum, out_ready, input out_valid, out_data);
    modport slave  (input in_valid, in_psum, out_ready, output out_valid, out_data);
endinterface

// File: rtl/psum_accum_core.sv
// Per-column partial-sum accumulator with valid/data delay line and drain handshake.
// Define PSUM_ACC_SAT_EN to clamp on overflow; otherwise sums wrap modulo 2^acc_bw.
module psum_accum_lane #(
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int depth   = 16,
    parameter int dly     = 1,
    parameter int pass_w  = 4,
    parameter int aw      = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               accum_en,
    input  logic [pass_w-1:0]  passes,
    input  logic               in_valid,
    input  logic [psum_bw-1:0] in_psum,
    input  logic [aw-1:0]      rd_ptr,
    output logic               finished,
    output logic               drop,
    output logic               ovf,
    output logic [acc_bw-1:0]  rd_data
);
    logic               d_vld;
    logic [psum_bw-1:0] d_psum;

    generate
        if (dly == 0) begin : g_pass
            assign d_vld  = in_valid;
            assign d_psum = in_psum;
        end else begin : g_dly
            logic [dly-1:0]              vld_pipe;
            logic [dly-1:0][psum_bw-1:0] dat_pipe;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= in_valid;
                    dat_pipe[0] <= in_psum;
                    for (int i = 1; i < dly; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        dat_pipe[i] <= dat_pipe[i-1];
                    end
                end
            end
            assign d_vld  = vld_pipe[dly-1];
            assign d_psum = dat_pipe[dly-1];
        end
    endgenerate

    logic [acc_bw-1:0]        acc [depth];
    logic [aw-1:0]            ptr;
    logic [pass_w-1:0]        pass;
    logic signed [acc_bw-1:0] psum_ext, acc_cur, acc_nxt;
    logic signed [acc_bw:0]   sum;
    logic                     upd, ovf_now;

    assign psum_ext = acc_bw'(signed'(d_psum));
    assign acc_cur  = acc[ptr];
    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    assign sum      = (acc_bw+1)'(acc_cur) + (acc_bw+1)'(psum_ext);
    assign ovf_now  = sum[acc_bw] ^ sum[acc_bw-1];

`ifdef PSUM_ACC_SAT_EN
    assign acc_nxt = !ovf_now ? sum[acc_bw-1:0] :
                     sum[acc_bw] ? {1'b1, {(acc_bw-1){1'b0}}} : {1'b0, {(acc_bw-1){1'b1}}};
`else
    assign acc_nxt = sum[acc_bw-1:0];
`endif

    assign finished = (pass == passes);
    assign upd      = d_vld && accum_en && !finished;
    assign drop     = d_vld && !upd;
    assign ovf      = upd && (pass != '0) && ovf_now;
    assign rd_data  = acc[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr  <= '0;
            pass <= '0;
            for (int i = 0; i < depth; i++) acc[i] <= '0;
        end else if (clr) begin
            ptr  <= '0;
            pass <= '0;
        end else if (upd) begin
            // Pass 0 overwrites, so stale contents from an earlier job never leak in.
            acc[ptr] <= (pass == '0) ? psum_ext : acc_nxt;
            if (ptr == aw'(depth-1)) begin
                ptr  <= '0;
                pass <= pass + 1'b1;
            end else begin
                ptr  <= ptr + 1'b1;
            end
        end
    end
endmodule

module psum_accum_core #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int depth   = 16,
    parameter int dly     = 1,
    parameter int pass_w  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [pass_w-1:0] cfg_passes,
    input  logic              cfg_relu,
    psum_accum_core_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              err_drop,
    output logic              err_ovf
);
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                   state;
    logic [pass_w-1:0]            passes_q;
    logic                         relu_q;
    logic [aw-1:0]                rd_ptr;
    logic                         start_acc, accum_en, out_valid;
    logic [col-1:0]               fin, drp, ovf, in_valid;
    logic [col-1:0][psum_bw-1:0]  in_psum;
    logic [col-1:0][acc_bw-1:0]   rd_data, out_word;

    assign in_valid  = bus.in_valid;
    assign in_psum   = bus.in_psum;
    assign start_acc = start && (state == S_IDLE);
    assign accum_en  = (state == S_ACCUM);
    assign out_valid = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    psum_accum_lane #(
        .psum_bw(psum_bw), .acc_bw(acc_bw), .depth(depth), .dly(dly), .pass_w(pass_w), .aw(aw)
    ) u_lane [col-1:0] (
        .clk(clk), .reset(reset), .clr(start_acc), .accum_en(accum_en), .passes(passes_q),
        .in_valid(in_valid), .in_psum(in_psum), .rd_ptr(rd_ptr),
        .finished(fin), .drop(drp), .ovf(ovf), .rd_data(rd_data)
    );

    // ReLU only shapes the output word; the bank keeps the signed sums.
    generate
        for (genvar c = 0; c < col; c++) begin : g_relu
            assign out_word[c] = (relu_q && rd_data[c][acc_bw-1]) ? '0 : rd_data[c];
        end
    endgenerate

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? out_word : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            passes_q <= '0;
            relu_q   <= 1'b0;
            rd_ptr   <= '0;
            err_drop <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            if (start_acc) begin
                passes_q <= (cfg_passes == '0) ? pass_w'(1) : cfg_passes;
                relu_q   <= cfg_relu;
            end
            err_drop <= (err_drop && !start_acc) || (|drp);
            err_ovf  <= (err_ovf && !start_acc) || (|ovf);
            case (state)
                S_IDLE:  if (start_acc) state <= S_ACCUM;
                S_ACCUM: if (&fin) begin
                    state  <= S_DRAIN;
                    rd_ptr <= '0;
                end
                S_DRAIN: if (bus.out_ready) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == aw'(depth-1)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
